// File: rtl/conversion_pkg.sv
// Shared types and decode helper for the serial conversion encoder/decoder pair.
package conversion_pkg;

   typedef enum logic {
      S0 = 1'b0,
      S1 = 1'b1
   } state_t;

   // Decoded bit plus the state that follows it
   typedef struct packed {
      logic   x;
      state_t nxt;
   } dec_t;

   // Inverse of the encoder: x = z ^ s, and the state toggles whenever x is 0
   function automatic dec_t decode_bit(input state_t s, input logic z);
      dec_t r;
      r.x   = z ^ (s == S1);
      r.nxt = r.x ? s : ((s == S0) ? S1 : S0);
      return r;
   endfunction

endpackage

// File: rtl/conversion_bit_decoder.sv
// Two-state Mealy inverse of the conversion encoder; sync forces S0 for the current bit.
module conversion_bit_decoder
   import conversion_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync,
   input  logic z,
   output logic x
);

   state_t state;
   state_t s_eff;
   dec_t   dec;

   // Mealy decode from the effective state (S0 on a sync bit)
   always_comb begin
      s_eff = sync ? S0 : state;
      dec   = decode_bit(s_eff, z);
   end

   assign x = dec.x;

   // State advances only on valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S0;
      end else if (en) begin
         state <= dec.nxt;
      end
   end

endmodule

// File: rtl/conversion_decoder_deser.sv
// Decodes the serial conversion stream and assembles DATA_W-bit words onto a valid/ready register.
module conversion_decoder_deser
   import conversion_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              in_sof,
   output logic              bit_x,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              frame_err
);

   localparam int unsigned       CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  idx;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] sreg_nxt;
   logic              x;
   logic              complete;
   logic              accept;

   conversion_bit_decoder u_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .sync  (in_sof),
      .z     (in_bit),
      .x     (x)
   );

   assign bit_x = x;

   // Bit index of the current bit; a start-of-frame bit always restarts at 0
   always_comb begin
      idx      = in_sof ? '0 : cnt;
      complete = in_valid && (idx == LAST);
      accept   = complete && (!out_valid || out_ready);
   end

   // Shift direction chosen so the first bit lands in the requested end of the word
   if (LSB_FIRST) begin : g_lsb_first
      assign sreg_nxt = {x, sreg[DATA_W-1:1]};
   end else begin : g_msb_first
      assign sreg_nxt = {sreg[DATA_W-2:0], x};
   end

   // Bit counter and shift register advance on valid bits only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (in_valid) begin
         cnt  <= (idx == LAST) ? '0 : idx + CNT_W'(1);
         sreg <= sreg_nxt;
      end
   end

   // Output register with valid/ready handshake; a word arriving while blocked is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out_data  <= sreg_nxt;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Single-cycle status pulses for dropped and truncated words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= complete && out_valid && !out_ready;
         frame_err <= in_valid && in_sof && (cnt != '0);
      end
   end

endmodule

// File: tb/tb_conversion_decoder_deser.sv
// Scoreboard bench for conversion_decoder_deser (DATA_W = 8, LSB first).
module tb_conversion_decoder_deser;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_bit;
   logic       in_sof;
   logic       bit_x;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic       frame_err;

   int         n_tests;
   int         n_fail;
   int         ov_cnt;
   int         fe_cnt;
   logic [7:0] exp_q[$];
   logic       ms;

   conversion_decoder_deser #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_sof    (in_sof),
      .bit_x     (bit_x),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one valid bit and check bit_x against the bench's own decoder model
   task automatic send_bit(input logic z, input logic sof);
      logic ex;
      in_valid = 1'b1;
      in_bit   = z;
      in_sof   = sof;
      if (sof) ms = 1'b0;
      ex = z ^ ms;
      #2;
      check("bit_x", 32'(bit_x), 32'(ex));
      if (!ex) ms = ~ms;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // z[0] is sent first; the expected word is queued as the last bit is driven
   task automatic send_word(input logic [7:0] z, input bit sof, input bit push,
                            input logic [7:0] exp, input bit gap);
      for (int i = 0; i < 8; i++) begin
         if (gap) idle(int'($urandom_range(0, 3)));
         if (i == 7 && push) exp_q.push_back(exp);
         send_bit(z[i], (sof && i == 0) ? 1'b1 : 1'b0);
      end
   endtask

   // Consumer side: pop and compare on every handshake, count status pulses
   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun) ov_cnt++;
         if (frame_err) fe_cnt++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_word", 32'(out_valid), 32'd0);
            else check("word", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   localparam logic [7:0] Z_A    = 8'b1001_0001;
   localparam logic [7:0] Z_ONES = 8'hFF;
   localparam logic [7:0] Z_ALT  = 8'b1010_1010;

   initial begin
      int ov0;
      int fe0;
      int budget;
      n_tests = 0; n_fail = 0; ov_cnt = 0; fe_cnt = 0; ms = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      #1;
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      idle(2);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Known word, latency-1 output
      send_word(Z_A, 1, 1, 8'h4D, 0);
      check("latency_valid", 32'(out_valid), 32'd1);
      check("latency_data", 32'(out_data), 32'h4D);

      // Extremes, back to back
      send_word(Z_ONES, 1, 1, 8'hFF, 0);
      send_word(Z_ALT, 0, 1, 8'h00, 0);
      idle(2);

      // Gapped input with backpressure
      out_ready = 1'b0;
      send_word(Z_A, 1, 1, 8'h4D, 1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'h4D);
         idle(1);
      end
      out_ready = 1'b1;
      idle(1);
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_data", 32'(out_data), 32'h4D);

      // Overrun: second word dropped, first retained
      ov0 = ov_cnt;
      out_ready = 1'b0;
      send_word(Z_A, 1, 1, 8'h4D, 0);
      send_word(Z_ONES, 1, 0, 8'h00, 0);
      check("ovr_pulse", 32'(overrun), 32'd1);
      idle(3);
      check("ovr_count", 32'(ov_cnt - ov0), 32'd1);
      check("ovr_data", 32'(out_data), 32'h4D);
      check("ovr_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      idle(1);
      send_word(Z_ONES, 1, 1, 8'hFF, 0);
      idle(2);

      // Resync after a 3-bit partial word
      fe0 = fe_cnt;
      for (int i = 0; i < 3; i++) send_bit(Z_A[i], (i == 0) ? 1'b1 : 1'b0);
      send_word(Z_A, 1, 1, 8'h4D, 0);
      idle(2);
      check("frame_err_count", 32'(fe_cnt - fe0), 32'd1);

      // Async reset mid-word while a word is pending
      out_ready = 1'b0;
      send_word(Z_A, 1, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) send_bit(Z_ONES[i], (i == 0) ? 1'b1 : 1'b0);
      #2 rst_n = 1'b0;
      ms = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_word(Z_A, 0, 1, 8'h4D, 0);

      // Drain the scoreboard with a bounded wait
      budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin
         idle(1);
         budget--;
      end
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
